// File: rtl/sm4_key_sched_ctrl_if.sv
// SM4 key-schedule bus: key request, round-key stream and read port.
// master drives requests and addresses, slave is the sequencer.
interface sm4_key_sched_ctrl_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         key_clear;
  logic         rk_valid;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_out;
  logic         keys_ready;
  logic         dec_mode;
  logic [4:0]   rk_rd_addr;
  logic [31:0]  rk_rd_data;

  modport master (
    output key_in, key_valid, key_clear,
    output dec_mode, rk_rd_addr,
    input  key_ready, rk_valid, rk_idx,
    input  rk_out, keys_ready, rk_rd_data
  );

  modport slave (
    input  key_in, key_valid, key_clear,
    input  dec_mode, rk_rd_addr,
    output key_ready, rk_valid, rk_idx,
    output rk_out, keys_ready, rk_rd_data
  );
endinterface

// File: rtl/sm4_key_sched_ctrl.sv
// Iterative SM4 key expansion: one round key per cycle for 32 rounds,
// streamed out and kept in a 32-entry file with a single read port.
module transform_for_key_exp (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic [31:0] b;

  assign b = {SBOX[din[31:24]], SBOX[din[23:16]],
              SBOX[din[15:8]],  SBOX[din[7:0]]};

  // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
  assign dout = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
endmodule

module sm4_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 32,
  parameter bit RD_REG     = 1'b1
) (
  input logic                clk,
  input logic                rst,
  sm4_key_sched_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  localparam logic [4:0]  LAST = 5'(NUM_ROUNDS - 1);
  localparam logic [31:0] CK0  = 32'h00070E15;
  localparam logic [127:0] FK  = {
    32'hA3B1BAC6, 32'h56AA3350,
    32'h677D9197, 32'hB27022DC
  };

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] ck;
  logic [31:0] ck_next;
  logic [31:0] tin;
  logic [31:0] tout;
  logic [31:0] rk_new;
  logic [127:0] k_load;

  logic        key_ready;
  logic        keys_ready;
  logic        rk_valid;
  logic [4:0]  rk_idx;
  logic [31:0] rk_out;

  logic [31:0] rk_file [32];
  logic [4:0]  rd_p;

  assign tin    = k1 ^ k2 ^ k3 ^ ck;
  assign rk_new = k0 ^ tout;
  assign k_load = bus.key_in ^ FK;

  // Each CK byte steps by 28 on its own; carries never cross bytes.
  assign ck_next = {ck[31:24] + 8'd28, ck[23:16] + 8'd28,
                    ck[15:8]  + 8'd28, ck[7:0]   + 8'd28};

  transform_for_key_exp u_t (
    .din  (tin),
    .dout (tout)
  );

  // Sequencer: accept key, run the rounds, report completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      k0         <= '0;
      k1         <= '0;
      k2         <= '0;
      k3         <= '0;
      ck         <= CK0;
      key_ready  <= 1'b1;
      keys_ready <= 1'b0;
      rk_valid   <= 1'b0;
      rk_idx     <= '0;
      rk_out     <= '0;
    end else if (bus.key_clear) begin
      state      <= IDLE;
      cnt        <= '0;
      key_ready  <= 1'b1;
      keys_ready <= 1'b0;
      rk_valid   <= 1'b0;
    end else begin
      rk_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.key_valid && key_ready) begin
            {k0, k1, k2, k3} <= k_load;
            cnt        <= '0;
            ck         <= CK0;
            keys_ready <= 1'b0;
            key_ready  <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          rk_out   <= rk_new;
          rk_idx   <= cnt;
          rk_valid <= 1'b1;
          {k0, k1, k2, k3} <= {k1, k2, k3, rk_new};
          ck  <= ck_next;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            state      <= DONE;
            keys_ready <= 1'b1;
            key_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-key file: written once per expansion round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rk_file[i] <= '0;
    end else if (state == EXPAND && !bus.key_clear) begin
      rk_file[cnt] <= rk_new;
    end
  end

  // Decrypt reads the file back to front: 31 - addr == ~addr.
  assign rd_p = bus.dec_mode ? ~bus.rk_rd_addr : bus.rk_rd_addr;

  generate
    if (RD_REG) begin : g_rd_reg
      logic [31:0] rd_q;
      // Registered read; sees the file before this edge's write.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rk_file[rd_p];
      end
      assign bus.rk_rd_data = rd_q;
    end else begin : g_rd_comb
      assign bus.rk_rd_data = rk_file[rd_p];
    end
  endgenerate

  assign bus.key_ready  = key_ready;
  assign bus.keys_ready = keys_ready;
  assign bus.rk_valid   = rk_valid;
  assign bus.rk_idx     = rk_idx;
  assign bus.rk_out     = rk_out;
endmodule
